// File: rtl/fifo_umbral.sv
// ---------------------------------------------------------------------------
// fifo_umbral
//   Single-clock FIFO with programmable almost-empty / almost-full thresholds
//   and a sticky overflow/underflow error flag. One instance per traffic
//   class; the empty and error bits feed the control FSM.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-low reset
//   umbral        [3:0] low threshold, [7:4] high threshold
//   wr_en/data_in write request and payload
//   rd_en         read request
//   data_out      registered read data (holds when no read is accepted)
//   valid_out     one-cycle pulse when data_out was updated by a read
//   count         current occupancy, 0..DEPTH
//   empty/full    count == 0 / count == DEPTH
//   almost_empty  count <= umbral[3:0]
//   almost_full   count >= umbral[7:4]
//   error         sticky overflow/underflow flag, cleared only by reset
// ---------------------------------------------------------------------------
module fifo_umbral #(
  parameter int DATA_W = 6,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        umbral,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic              error
);

  localparam int                DEPTH   = 1 << ADDR_W;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              valid_q, valid_d;
  logic              error_q, error_d;

  logic              empty_s, full_s;
  logic              wr_acc_s, rd_acc_s;
  logic [7:0]        count8_s;

  // Status flags decode only the registered occupancy, never the requests.
  always_comb begin
    count8_s = 8'(count_q);
    empty_s  = (count_q == {CNT_W{1'b0}});
    full_s   = (count_q == DEPTH_C);
  end

  assign count        = count_q;
  assign empty        = empty_s;
  assign full         = full_s;
  // Thresholds beyond DEPTH fall out of the plain comparisons naturally.
  assign almost_empty = (count8_s <= {4'h0, umbral[3:0]});
  assign almost_full  = (count8_s >= {4'h0, umbral[7:4]});
  assign data_out     = data_out_q;
  assign valid_out    = valid_q;
  assign error        = error_q;

  // Accept decisions and next-state computation for pointers, count and flags.
  always_comb begin
    // A write into a full FIFO is still fine when a read frees a slot.
    wr_acc_s = wr_en && (!full_s || rd_en);
    // Reads never look through to data_in, so an empty FIFO rejects them.
    rd_acc_s = rd_en && !empty_s;

    if (wr_acc_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_acc_s) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      data_out_d = mem_q[rd_ptr_q];
    end else begin
      rd_ptr_d   = rd_ptr_q;
      data_out_d = data_out_q;
    end

    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    valid_d = rd_acc_s;

    if ((wr_en && full_s && !rd_en) || (rd_en && empty_s)) begin
      error_d = 1'b1;
    end else begin
      error_d = error_q;
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= {ADDR_W{1'b0}};
      rd_ptr_q   <= {ADDR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      data_out_q <= {DATA_W{1'b0}};
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
    end
  end

  // Storage array; contents are left untouched by reset since count gates reads.
  always_ff @(posedge clk) begin
    if (reset && wr_acc_s) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

endmodule
